// File: rtl/wb_debug_master_b3.sv
// Debug-port to Wishbone B3 classic single-beat master.
// Each accepted debug strobe runs one WB transaction with bounded retry, per-attempt timeout and a status code.
module wb_debug_master_b3 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3,
    parameter int RETRY_GAP  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dbg_stb,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_adr,
    input  logic [DATA_WIDTH-1:0] dbg_wdat,
    output logic [DATA_WIDTH-1:0] dbg_rdat,
    output logic                  dbg_ack,
    output logic                  dbg_err,
    output logic [1:0]            dbg_status,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [3:0]            wb_sel,
    output logic [DATA_WIDTH-1:0] wb_dat_m2s,
    input  logic [DATA_WIDTH-1:0] wb_dat_s2m,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    input  logic                  wb_rty,
    output logic [2:0]            wb_cti,
    output logic                  wb_bte
);

    // state | meaning
    // IDLE  | waiting for dbg_stb
    // BUS   | wb_cyc high, sampling ack/err/rty/timeout
    // GAP   | wb_cyc low between a rty and the re-issue
    // DONE  | dbg_ack/dbg_err pulse
    // HOLD  | waiting for dbg_stb to drop
    typedef enum logic [2:0] {ST_IDLE, ST_BUS, ST_GAP, ST_DONE, ST_HOLD} state_t;

    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_BERR  = 2'b01;
    localparam logic [1:0] ST_RTYX  = 2'b10;
    localparam logic [1:0] ST_TMO   = 2'b11;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [DATA_WIDTH-1:0]  dat_q, dat_d;
    logic [DATA_WIDTH-1:0]  rdat_q, rdat_d;
    logic                   we_q, we_d;
    logic                   cyc_q, cyc_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [1:0]             status_q, status_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [RTY_W-1:0]       retry_cnt_q, retry_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   finish;
    logic [1:0]             fin_status;

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rdat_d      = rdat_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        status_d    = status_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        finish      = 1'b0;
        fin_status  = ST_OK;

        case (state_q)
            ST_IDLE: begin
                if (dbg_stb) begin
                    adr_d       = dbg_adr;
                    dat_d       = dbg_wdat;
                    we_d        = dbg_we;
                    retry_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    status_d    = ST_OK;
                    cyc_d       = 1'b1;
                    state_d     = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_ack) begin
                    if (!we_q) begin
                        rdat_d = wb_dat_s2m;
                    end
                    finish = 1'b1;
                end else if (wb_err) begin
                    finish     = 1'b1;
                    fin_status = ST_BERR;
                end else if (wb_rty) begin
                    if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + RTY_W'(1);
                        gap_cnt_d   = GAP_W'(RETRY_GAP - 1);
                        cyc_d       = 1'b0;
                        state_d     = ST_GAP;
                    end else begin
                        finish     = 1'b1;
                        fin_status = ST_RTYX;
                    end
                end else if (TIMEOUT > 0) begin
                    if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        finish     = 1'b1;
                        fin_status = ST_TMO;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    tmo_cnt_d = '0;
                    cyc_d     = 1'b1;
                    state_d   = ST_BUS;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!dbg_stb) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        // Status and ack are registered together so dbg_err is valid in the ack cycle.
        if (finish) begin
            cyc_d    = 1'b0;
            ack_d    = 1'b1;
            err_d    = (fin_status != ST_OK);
            status_d = fin_status;
            state_d  = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            rdat_q      <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            status_q    <= ST_OK;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rdat_q      <= rdat_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            status_q    <= status_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign dbg_rdat   = rdat_q;
    assign dbg_ack    = ack_q;
    assign dbg_err    = err_q;
    assign dbg_status = status_q;
    assign wb_adr     = adr_q;
    assign wb_cyc     = cyc_q;
    assign wb_stb     = cyc_q;
    assign wb_we      = we_q;
    assign wb_sel     = {4{cyc_q}};
    assign wb_dat_m2s = dat_q;
    assign wb_cti     = 3'b000;
    assign wb_bte     = 1'b0;

endmodule

// File: tb/tb_wb_debug_master_b3.sv
// Self-checking bench for wb_debug_master_b3: scripted slave responses per attempt, outcome predicted from the transaction rules.
module tb_wb_debug_master_b3;

    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 3;
    localparam int RETRY_GAP = 2;

    localparam int K_NONE   = 0;
    localparam int K_ACK    = 1;
    localparam int K_ERR    = 2;
    localparam int K_RTY    = 3;
    localparam int K_ACKERR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dbg_stb = 1'b0;
    logic        dbg_we = 1'b0;
    logic [31:0] dbg_adr = '0;
    logic [31:0] dbg_wdat = '0;
    logic [31:0] dbg_rdat;
    logic        dbg_ack;
    logic        dbg_err;
    logic [1:0]  dbg_status;
    logic [31:0] wb_adr;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_m2s;
    logic [31:0] wb_dat_s2m = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        wb_rty = 1'b0;
    logic [2:0]  wb_cti;
    logic        wb_bte;

    wb_debug_master_b3 #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT),
        .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_stb(dbg_stb), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdat(dbg_wdat),
        .dbg_rdat(dbg_rdat), .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_status(dbg_status),
        .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_dat_m2s(wb_dat_m2s), .wb_dat_s2m(wb_dat_s2m),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
        .wb_cti(wb_cti), .wb_bte(wb_bte)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // slave script: one entry per attempt (kind, cycle of response within the burst)
    int plan_kind[$];
    int plan_dly[$];

    // observations
    int          burst_len[$];
    int          gap_len[$];
    logic [31:0] burst_adr[$];
    int          ack_cnt = 0;
    int          cyc_run = 0;
    int          gap_run = 0;
    int          stb_bad = 0;
    int          sel_bad = 0;
    logic        obs_err = 1'b0;
    logic [1:0]  obs_status = 2'b00;
    logic [31:0] obs_rdat = '0;
    logic        obs_we = 1'b0;
    logic [31:0] obs_dat = '0;

    // reference model outputs
    int          exp_len[$];
    logic [1:0]  exp_status;
    logic [31:0] model_rdat = '0;

    always @(negedge clk) begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_rty = 1'b0;
        if (wb_stb !== wb_cyc) stb_bad++;
        if (wb_sel !== (wb_cyc ? 4'hF : 4'h0)) sel_bad++;
        if (wb_cyc === 1'b1) begin
            if (cyc_run == 0) begin
                if (burst_len.size() > 0) gap_len.push_back(gap_run);
                burst_adr.push_back(wb_adr);
                gap_run = 0;
            end
            cyc_run++;
            obs_we  = wb_we;
            obs_dat = wb_dat_m2s;
            if (plan_kind.size() > 0 && cyc_run == plan_dly[0]) begin
                case (plan_kind[0])
                    K_ACK:    wb_ack = 1'b1;
                    K_ERR:    wb_err = 1'b1;
                    K_RTY:    wb_rty = 1'b1;
                    K_ACKERR: begin wb_ack = 1'b1; wb_err = 1'b1; end
                    default:  ;
                endcase
            end
        end else begin
            if (cyc_run > 0) begin
                burst_len.push_back(cyc_run);
                if (plan_kind.size() > 0) begin
                    void'(plan_kind.pop_front());
                    void'(plan_dly.pop_front());
                end
                cyc_run = 0;
            end
            gap_run++;
        end
        if (dbg_ack === 1'b1) begin
            ack_cnt++;
            obs_err    = dbg_err;
            obs_status = dbg_status;
            obs_rdat   = dbg_rdat;
        end
    end

    task automatic add_step(input int kind, input int dly);
        plan_kind.push_back(kind);
        plan_dly.push_back(dly);
    endtask

    // Predict the outcome from the transaction rules, then drive one debug request.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat, input int hold);
        int  k[$];
        int  d[$];
        int  retries;
        bit  fin;
        int  n;
        @(posedge clk); #2;
        burst_len.delete(); gap_len.delete(); burst_adr.delete();
        ack_cnt = 0; gap_run = 0;
        k = plan_kind; d = plan_dly;
        exp_len.delete(); exp_status = 2'b00; retries = 0; fin = 0;
        for (int i = 0; i < k.size() && !fin; i++) begin
            if (k[i] == K_ACK || k[i] == K_ACKERR) begin
                exp_len.push_back(d[i]); exp_status = 2'b00; fin = 1;
                if (!we) model_rdat = wb_dat_s2m;
            end else if (k[i] == K_ERR) begin
                exp_len.push_back(d[i]); exp_status = 2'b01; fin = 1;
            end else if (k[i] == K_RTY) begin
                exp_len.push_back(d[i]);
                if (retries < MAX_RETRY) retries++;
                else begin exp_status = 2'b10; fin = 1; end
            end else begin
                exp_len.push_back(TIMEOUT); exp_status = 2'b11; fin = 1;
            end
        end
        dbg_we = we; dbg_adr = adr; dbg_wdat = wdat; dbg_stb = 1'b1;
        @(posedge clk); #2;
        dbg_adr = $urandom; dbg_wdat = $urandom; dbg_we = ~we;
        n = 0;
        while (ack_cnt == 0 && n < 200) begin @(posedge clk); n++; end
        checks++;
        if (ack_cnt == 0) begin errors++; $display("FAIL ack_wait got=no dbg_ack exp=dbg_ack within 200 cycles"); end
        repeat (hold) @(posedge clk);
        @(posedge clk); #2;
        dbg_stb = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_m2s, dbg_rdat, dbg_ack, dbg_err, dbg_status, wb_cti, wb_bte} !== '0) begin
            errors++; $display("FAIL reset_outputs got cyc=%b sel=%h rdat=%h ack=%b status=%b exp=all zero", wb_cyc, wb_sel, dbg_rdat, dbg_ack, dbg_status);
        end
        rst_n = 1'b1;
        model_rdat = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_idle got cyc=%b exp=0", wb_cyc); end
    endtask

    task automatic test_read;
        wb_dat_s2m = 32'hDEAD_BEEF;
        add_step(K_ACK, 3);
        run_txn(1'b0, 32'h100, 32'h0, 0);
        checks++; if (burst_len.size() != 1 || burst_len[0] != 3) begin errors++; $display("FAIL read_cyc_len got bursts=%0d exp=1 burst of 3", burst_len.size()); end
        checks++; if (obs_rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdat got=%h exp=deadbeef", obs_rdat); end
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL read_ack_cnt got=%0d exp=1", ack_cnt); end
        checks++; if (obs_err !== 1'b0 || obs_status !== 2'b00) begin errors++; $display("FAIL read_status got err=%b st=%b exp err=0 st=00", obs_err, obs_status); end
        checks++; if (burst_adr.size() != 1 || burst_adr[0] !== 32'h100 || obs_we !== 1'b0) begin errors++; $display("FAIL read_bus got adr_bursts=%0d we=%b exp adr=100 we=0", burst_adr.size(), obs_we); end
    endtask

    task automatic test_write;
        wb_dat_s2m = $urandom;
        add_step(K_ACK, 1);
        run_txn(1'b1, 32'h40, 32'h1234_5678, 0);
        checks++; if (obs_we !== 1'b1 || obs_dat !== 32'h1234_5678) begin errors++; $display("FAIL write_bus got we=%b dat=%h exp we=1 dat=12345678", obs_we, obs_dat); end
        checks++; if (burst_len.size() != 1 || burst_len[0] != 1) begin errors++; $display("FAIL write_cyc_len got bursts=%0d exp=1 burst of 1", burst_len.size()); end
        checks++; if (dbg_rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_rdat_kept got=%h exp=deadbeef", dbg_rdat); end
        checks++; if (sel_bad != 0 || stb_bad != 0) begin errors++; $display("FAIL write_sel_stb got sel_bad=%0d stb_bad=%0d exp=0", sel_bad, stb_bad); end
    endtask

    task automatic test_retry;
        wb_dat_s2m = 32'hCAFE_0001;
        add_step(K_RTY, 1); add_step(K_RTY, 2); add_step(K_ACK, 1);
        run_txn(1'b0, 32'h200, 32'h0, 0);
        checks++; if (burst_len.size() != 3) begin errors++; $display("FAIL retry_bursts got=%0d exp=3", burst_len.size()); end
        checks++; if (gap_len.size() != 2 || gap_len[0] != RETRY_GAP || gap_len[1] != RETRY_GAP) begin errors++; $display("FAIL retry_gap got n=%0d exp two gaps of %0d", gap_len.size(), RETRY_GAP); end
        checks++; if (obs_status !== 2'b00 || obs_rdat !== 32'hCAFE_0001) begin errors++; $display("FAIL retry_result got st=%b rdat=%h exp st=00 rdat=cafe0001", obs_status, obs_rdat); end
    endtask

    task automatic test_retry_exhaust;
        wb_dat_s2m = $urandom;
        for (int i = 0; i <= MAX_RETRY; i++) add_step(K_RTY, 1 + (i % 3));
        run_txn(1'b0, 32'h300, 32'h0, 0);
        checks++; if (burst_len.size() != MAX_RETRY + 1) begin errors++; $display("FAIL rtyx_bursts got=%0d exp=%0d", burst_len.size(), MAX_RETRY + 1); end
        checks++; if (obs_err !== 1'b1 || obs_status !== 2'b10) begin errors++; $display("FAIL rtyx_status got err=%b st=%b exp err=1 st=10", obs_err, obs_status); end
        checks++; if (obs_rdat !== model_rdat) begin errors++; $display("FAIL rtyx_rdat got=%h exp=%h", obs_rdat, model_rdat); end
    endtask

    task automatic test_timeout;
        add_step(K_NONE, 0);
        run_txn(1'b1, 32'h400, 32'h5555_AAAA, 0);
        checks++; if (burst_len.size() != 1 || burst_len[0] != TIMEOUT) begin errors++; $display("FAIL tmo_len got bursts=%0d first=%0d exp=1 burst of %0d", burst_len.size(), (burst_len.size() > 0) ? burst_len[0] : -1, TIMEOUT); end
        checks++; if (obs_err !== 1'b1 || obs_status !== 2'b11) begin errors++; $display("FAIL tmo_status got err=%b st=%b exp err=1 st=11", obs_err, obs_status); end
        wb_dat_s2m = 32'h0BAD_F00D;
        add_step(K_ACKERR, 2);
        run_txn(1'b0, 32'h404, 32'h0, 0);
        checks++; if (obs_err !== 1'b0 || obs_status !== 2'b00 || obs_rdat !== 32'h0BAD_F00D) begin errors++; $display("FAIL ackerr_prio got err=%b st=%b rdat=%h exp err=0 st=00 rdat=0badf00d", obs_err, obs_status, obs_rdat); end
    endtask

    task automatic test_hold;
        wb_dat_s2m = $urandom;
        add_step(K_ACK, 1);
        run_txn(1'b1, 32'h500, 32'h1111_2222, 6);
        checks++; if (burst_len.size() != 1 || ack_cnt != 1) begin errors++; $display("FAIL hold_single got bursts=%0d acks=%0d exp=1 and 1", burst_len.size(), ack_cnt); end
        wb_dat_s2m = 32'h7777_8888;
        add_step(K_ACK, 2);
        run_txn(1'b0, 32'h504, 32'h0, 0);
        checks++; if (ack_cnt != 1 || obs_rdat !== 32'h7777_8888) begin errors++; $display("FAIL back_to_back got acks=%0d rdat=%h exp=1 and 77778888", ack_cnt, obs_rdat); end
    endtask

    task automatic test_async_reset;
        int n;
        add_step(K_NONE, 0);
        @(posedge clk); #2;
        ack_cnt = 0;
        dbg_we = 1'b0; dbg_adr = 32'h600; dbg_stb = 1'b1;
        n = 0;
        while (wb_cyc !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
        @(posedge clk); #2;
        checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL arst_pre got cyc=%b exp=1", wb_cyc); end
        rst_n = 1'b0;
        #1;
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL arst_drop got cyc=%b stb=%b exp=0 0", wb_cyc, wb_stb); end
        dbg_stb = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        model_rdat = '0;
        repeat (4) @(posedge clk);
        #2;
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL arst_no_ack got acks=%0d exp=0", ack_cnt); end
        checks++; if (dbg_rdat !== 32'h0 || dbg_status !== 2'b00 || wb_cyc !== 1'b0) begin errors++; $display("FAIL arst_state got rdat=%h st=%b cyc=%b exp 0", dbg_rdat, dbg_status, wb_cyc); end
    endtask

    task automatic test_random;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          r;
        int          kind;
        int          bad;
        for (int it = 0; it < 24; it++) begin
            we = 1'($urandom_range(0, 1));
            adr = $urandom; wdat = $urandom; wb_dat_s2m = $urandom;
            for (int a = 0; a <= MAX_RETRY; a++) begin
                r = $urandom_range(0, 9);
                kind = (r < 4) ? K_ACK : (r == 4) ? K_ERR : (r < 8) ? K_RTY : (r == 8) ? K_NONE : K_ACKERR;
                add_step(kind, (kind == K_NONE) ? 0 : $urandom_range(1, TIMEOUT));
                if (kind != K_RTY) break;
            end
            run_txn(we, adr, wdat, $urandom_range(0, 3));
            checks++; if (ack_cnt != 1) begin errors++; $display("FAIL rand%0d_acks got=%0d exp=1", it, ack_cnt); end
            checks++; if (obs_status !== exp_status || obs_err !== (exp_status != 2'b00)) begin errors++; $display("FAIL rand%0d_status got st=%b err=%b exp st=%b", it, obs_status, obs_err, exp_status); end
            checks++; if (obs_rdat !== model_rdat || dbg_rdat !== model_rdat) begin errors++; $display("FAIL rand%0d_rdat got=%h exp=%h", it, dbg_rdat, model_rdat); end
            bad = (burst_len.size() != exp_len.size()) ? 1 : 0;
            for (int b = 0; b < burst_len.size() && b < exp_len.size(); b++) if (burst_len[b] != exp_len[b]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_bursts got n=%0d exp n=%0d (len errors %0d)", it, burst_len.size(), exp_len.size(), bad); end
            bad = (gap_len.size() + 1 != burst_len.size()) ? 1 : 0;
            foreach (gap_len[g]) if (gap_len[g] != RETRY_GAP) bad++;
            foreach (burst_adr[a]) if (burst_adr[a] !== adr) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_gaps_adr got errors=%0d exp=0", it, bad); end
            checks++; if (obs_we !== we || (we && obs_dat !== wdat)) begin errors++; $display("FAIL rand%0d_we_dat got we=%b dat=%h exp we=%b dat=%h", it, obs_we, obs_dat, we, wdat); end
        end
        checks++; if (sel_bad != 0 || stb_bad != 0) begin errors++; $display("FAIL rand_sel_stb got sel_bad=%0d stb_bad=%0d exp=0", sel_bad, stb_bad); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_retry();
        test_retry_exhaust();
        test_timeout();
        test_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=simulation still running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
